id_ex_stage: RTL and testbench

ID/EX pipeline stage of the 5-stage RV32I core. It registers decoded operands and control from decode and applies EX/MEM and MEM/WB forwarding to produce the ALU operands and 4-bit ALU control. It also detects load-use hazards, stalls decode, and inserts bubbles on stall or branch flush.

---
 rtl/id_ex_stage.sv | 180 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, load-use stall and bubble insertion
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_i,

    // Decode-side instruction
    input  logic            id_valid_i,
    input  logic [RAW-1:0]  id_rs1_i,
    input  logic [RAW-1:0]  id_rs2_i,
    input  logic [RAW-1:0]  id_rd_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic            id_alusrc_i,
    input  logic [3:0]      id_aluctrl_i,
    input  logic            id_regwrite_i,
    input  logic            id_memread_i,
    input  logic            id_memwrite_i,
    input  logic            id_memtoreg_i,
    input  logic            id_branch_i,

    // Taken branch / jump resolved in EX
    input  logic            flush_i,

    // EX/MEM writer
    input  logic            exmem_regwrite_i,
    input  logic [RAW-1:0]  exmem_rd_i,
    input  logic [XLEN-1:0] exmem_result_i,

    // MEM/WB writer (also the register-file write port)
    input  logic            memwb_regwrite_i,
    input  logic [RAW-1:0]  memwb_rd_i,
    input  logic [XLEN-1:0] memwb_data_i,

    // Hazard and EX-side outputs
    output logic            stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] data1_o,
    output logic [XLEN-1:0] data2_o,
    output logic [3:0]      aluctrl_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [RAW-1:0]  ex_rd_o,
    output logic            ex_regwrite_o,
    output logic            ex_memread_o,
    output logic            ex_memwrite_o,
    output logic            ex_memtoreg_o,
    output logic            ex_branch_o
);

    // ------------------------------------------------------------------
    // EX register bank
    // ------------------------------------------------------------------
    logic            ex_valid;
    logic [RAW-1:0]  ex_rs1_idx;
    logic [RAW-1:0]  ex_rs2_idx;
    logic [RAW-1:0]  ex_rd;
    logic [XLEN-1:0] ex_rs1_val;
    logic [XLEN-1:0] ex_rs2_val;
    logic [XLEN-1:0] ex_imm;
    logic            ex_alusrc;
    logic [3:0]      ex_aluctrl;
    logic            ex_regwrite;
    logic            ex_memread;
    logic            ex_memwrite;
    logic            ex_memtoreg;
    logic            ex_branch;

    // ------------------------------------------------------------------
    // Combinational hazard / bypass / forwarding signals
    // ------------------------------------------------------------------
    logic            rs1_hit;
    logic            rs2_hit;
    logic            hazard;
    logic            stall;
    logic            bubble;

    logic            id_byp1;
    logic            id_byp2;
    logic [XLEN-1:0] id_rs1_val;
    logic [XLEN-1:0] id_rs2_val;

    logic            ex1_from_exmem;
    logic            ex1_from_memwb;
    logic            ex2_from_exmem;
    logic            ex2_from_memwb;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    // Load-use detection: a load in EX whose destination is read in ID.
    // x0 never creates a dependency.
    always_comb begin
        rs1_hit = (id_rs1_i == ex_rd);
        rs2_hit = (id_rs2_i == ex_rd);
        hazard  = ex_valid && ex_memread && (ex_rd != '0) && id_valid_i
                  && (rs1_hit || rs2_hit);
        // A flushed ID instruction is dead, so it must not hold the front end.
        stall   = hazard && !flush_i;
        bubble  = flush_i || stall || !id_valid_i;
    end

    // Register-file write bypass into the captured operands: the register file
    // has no internal write-through, so a same-cycle MEM/WB write is picked up here.
    always_comb begin
        id_byp1    = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rs1_i);
        id_byp2    = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == id_rs2_i);
        id_rs1_val = id_byp1 ? memwb_data_i : id_rs1_data_i;
        id_rs2_val = id_byp2 ? memwb_data_i : id_rs2_data_i;
    end

    // Capture decode into EX, or load a full bubble (all fields zero, ALU op ADD).
    always_ff @(posedge clk_i) begin
        if (rst_i || bubble) begin
            ex_valid    <= 1'b0;
            ex_rs1_idx  <= '0;
            ex_rs2_idx  <= '0;
            ex_rd       <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_alusrc   <= 1'b0;
            ex_aluctrl  <= 4'b0000;
            ex_regwrite <= 1'b0;
            ex_memread  <= 1'b0;
            ex_memwrite <= 1'b0;
            ex_memtoreg <= 1'b0;
            ex_branch   <= 1'b0;
        end else begin
            ex_valid    <= id_valid_i;
            ex_rs1_idx  <= id_rs1_i;
            ex_rs2_idx  <= id_rs2_i;
            ex_rd       <= id_rd_i;
            ex_rs1_val  <= id_rs1_val;
            ex_rs2_val  <= id_rs2_val;
            ex_imm      <= id_imm_i;
            ex_alusrc   <= id_alusrc_i;
            ex_aluctrl  <= id_aluctrl_i;
            ex_regwrite <= id_regwrite_i;
            ex_memread  <= id_memread_i;
            ex_memwrite <= id_memwrite_i;
            ex_memtoreg <= id_memtoreg_i;
            ex_branch   <= id_branch_i;
        end
    end

    // Operand forwarding: EX/MEM is the younger result and wins over MEM/WB.
    always_comb begin
        ex1_from_exmem = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs1_idx);
        ex1_from_memwb = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs1_idx);
        ex2_from_exmem = exmem_regwrite_i && (exmem_rd_i != '0) && (exmem_rd_i == ex_rs2_idx);
        ex2_from_memwb = memwb_regwrite_i && (memwb_rd_i != '0) && (memwb_rd_i == ex_rs2_idx);

        if (ex1_from_exmem)      fwd1 = exmem_result_i;
        else if (ex1_from_memwb) fwd1 = memwb_data_i;
        else                     fwd1 = ex_rs1_val;

        if (ex2_from_exmem)      fwd2 = exmem_result_i;
        else if (ex2_from_memwb) fwd2 = memwb_data_i;
        else                     fwd2 = ex_rs2_val;
    end

    // Output drive: operand 2 selects the immediate; store data is always rs2.
    always_comb begin
        stall_o         = stall;
        ex_valid_o      = ex_valid;
        data1_o         = fwd1;
        data2_o         = ex_alusrc ? ex_imm : fwd2;
        ex_store_data_o = fwd2;
        aluctrl_o       = ex_aluctrl;
        ex_rd_o         = ex_rd;
        ex_regwrite_o   = ex_regwrite;
        ex_memread_o    = ex_memread;
        ex_memwrite_o   = ex_memwrite;
        ex_memtoreg_o   = ex_memtoreg;
        ex_branch_o     = ex_branch;
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        id_valid_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [31:0] id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic        id_alusrc_i;
    logic [3:0]  id_aluctrl_i;
    logic        id_regwrite_i, id_memread_i, id_memwrite_i, id_memtoreg_i, id_branch_i;
    logic        flush_i;
    logic        exmem_regwrite_i;
    logic [4:0]  exmem_rd_i;
    logic [31:0] exmem_result_i;
    logic        memwb_regwrite_i;
    logic [4:0]  memwb_rd_i;
    logic [31:0] memwb_data_i;
    logic        stall_o, ex_valid_o;
    logic [31:0] data1_o, data2_o, ex_store_data_o;
    logic [3:0]  aluctrl_o;
    logic [4:0]  ex_rd_o;
    logic        ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_branch_o;

    int n_cmp = 0;
    int n_err = 0;

    id_ex_stage #(.XLEN(32), .RAW(5)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i),
        .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
        .id_alusrc_i(id_alusrc_i), .id_aluctrl_i(id_aluctrl_i),
        .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i), .id_memwrite_i(id_memwrite_i),
        .id_memtoreg_i(id_memtoreg_i), .id_branch_i(id_branch_i),
        .flush_i(flush_i),
        .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
        .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
        .stall_o(stall_o), .ex_valid_o(ex_valid_o), .data1_o(data1_o), .data2_o(data2_o),
        .aluctrl_o(aluctrl_o), .ex_store_data_o(ex_store_data_o), .ex_rd_o(ex_rd_o),
        .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o),
        .ex_memtoreg_o(ex_memtoreg_o), .ex_branch_o(ex_branch_o)
    );

    always #5 clk_i = ~clk_i;

    // Compare one observed value against the expected one.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic id_nop();
        id_valid_i    = 1'b0;
        id_rs1_i      = '0; id_rs2_i = '0; id_rd_i = '0;
        id_rs1_data_i = '0; id_rs2_data_i = '0; id_imm_i = '0;
        id_alusrc_i   = 1'b0; id_aluctrl_i = 4'b0000;
        id_regwrite_i = 1'b0; id_memread_i = 1'b0; id_memwrite_i = 1'b0;
        id_memtoreg_i = 1'b0; id_branch_i = 1'b0;
    endtask

    task automatic writers_off();
        exmem_regwrite_i = 1'b0; exmem_rd_i = '0; exmem_result_i = '0;
        memwb_regwrite_i = 1'b0; memwb_rd_i = '0; memwb_data_i = '0;
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Capture a load with rd=4 into EX.
    task automatic load_lw4();
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd1; id_rs1_data_i = 32'h100; id_rd_i = 5'd4;
        id_imm_i = 32'd4; id_alusrc_i = 1'b1; id_regwrite_i = 1'b1;
        id_memread_i = 1'b1; id_memtoreg_i = 1'b1;
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got 0x%08h expected 0x%08h", 0, 1);
        $fatal(1, "timeout");
    end

    initial begin
        rst_i = 1'b1; flush_i = 1'b0;
        writers_off();
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd1; id_rs1_data_i = 32'h5;
        id_aluctrl_i = 4'b0110; id_rd_i = 5'd9; id_regwrite_i = 1'b1;
        #1;
        step(); step();

        // Reset state
        check("rst_valid",  {31'd0, ex_valid_o}, 32'd0);
        check("rst_alu",    {28'd0, aluctrl_o}, 32'd0);
        check("rst_stall",  {31'd0, stall_o}, 32'd0);
        check("rst_data1",  data1_o, 32'd0);
        check("rst_data2",  data2_o, 32'd0);
        check("rst_store",  ex_store_data_o, 32'd0);
        check("rst_rd",     {27'd0, ex_rd_o}, 32'd0);
        check("rst_rw",     {31'd0, ex_regwrite_o}, 32'd0);
        rst_i = 1'b0;

        // Plain capture of ADD x3, x1(5), x2(7)
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd1; id_rs1_data_i = 32'd5;
        id_rs2_i = 5'd2; id_rs2_data_i = 32'd7; id_rd_i = 5'd3; id_regwrite_i = 1'b1;
        step();
        check("cap_data1", data1_o, 32'd5);
        check("cap_data2", data2_o, 32'd7);
        check("cap_alu",   {28'd0, aluctrl_o}, 32'd0);
        check("cap_valid", {31'd0, ex_valid_o}, 32'd1);
        check("cap_rd",    {27'd0, ex_rd_o}, 32'd3);
        check("cap_rw",    {31'd0, ex_regwrite_o}, 32'd1);

        // Forward priority on rs1=3
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd3; id_rs1_data_i = 32'h33;
        id_rs2_i = 5'd5; id_rs2_data_i = 32'h55; id_aluctrl_i = 4'b0011; id_rd_i = 5'd7;
        step();
        id_nop();
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd3; exmem_result_i = 32'h11;
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd3; memwb_data_i = 32'h22;
        #1;
        check("fwd_exmem", data1_o, 32'h11);
        check("fwd_alu",   {28'd0, aluctrl_o}, 32'd3);
        check("fwd_rs2",   data2_o, 32'h55);
        exmem_regwrite_i = 1'b0;
        #1;
        check("fwd_memwb", data1_o, 32'h22);
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd0; memwb_rd_i = 5'd0;
        #1;
        check("fwd_x0",    data1_o, 32'h33);
        writers_off();

        // Register-file write bypass at capture (rs1), and not for x0 (rs2)
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd1; id_rs1_data_i = 32'd5;
        id_rs2_i = 5'd0; id_rs2_data_i = 32'h0;
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd1; memwb_data_i = 32'h77;
        step();
        writers_off();
        #1;
        check("idbyp_rs1", data1_o, 32'h77);
        check("idbyp_x0",  data2_o, 32'h0);

        // Load-use on rs2
        load_lw4();
        check("lw_memread", {31'd0, ex_memread_o}, 32'd1);
        check("lw_data2",   data2_o, 32'd4);
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd7; id_rs1_data_i = 32'd1;
        id_rs2_i = 5'd4; id_rs2_data_i = 32'd0; id_rd_i = 5'd8;
        id_aluctrl_i = 4'b0001; id_regwrite_i = 1'b1;
        #1;
        check("lu_stall", {31'd0, stall_o}, 32'd1);
        step();
        check("lu_bub_valid", {31'd0, ex_valid_o}, 32'd0);
        check("lu_bub_mr",    {31'd0, ex_memread_o}, 32'd0);
        check("lu_bub_stall", {31'd0, stall_o}, 32'd0);
        // load now in MEM; SUB captured this edge
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd4; exmem_result_i = 32'h104;
        step();
        check("lu_sub_valid", {31'd0, ex_valid_o}, 32'd1);
        check("lu_sub_alu",   {28'd0, aluctrl_o}, 32'd1);
        writers_off();
        id_nop();
        #1;
        check("lu_sub_stale", data2_o, 32'd0);
        memwb_regwrite_i = 1'b1; memwb_rd_i = 5'd4; memwb_data_i = 32'h99;
        #1;
        check("lu_sub_fwd",   data2_o, 32'h99);
        check("lu_sub_stall", {31'd0, stall_o}, 32'd0);
        writers_off();

        // Flush beats hazard
        load_lw4();
        id_nop();
        id_valid_i = 1'b1; id_rs2_i = 5'd4; id_rd_i = 5'd8; id_aluctrl_i = 4'b0001;
        id_regwrite_i = 1'b1; id_rs1_data_i = 32'h5;
        flush_i = 1'b1;
        #1;
        check("fl_stall", {31'd0, stall_o}, 32'd0);
        step();
        flush_i = 1'b0;
        check("fl_valid", {31'd0, ex_valid_o}, 32'd0);
        check("fl_ctrl",  {26'd0, ex_regwrite_o, ex_memread_o, ex_memwrite_o,
                           ex_memtoreg_o, ex_branch_o, 1'b0}, 32'd0);
        check("fl_rd",    {27'd0, ex_rd_o}, 32'd0);
        check("fl_alu",   {28'd0, aluctrl_o}, 32'd0);
        check("fl_data1", data1_o, 32'd0);

        // Load to x0 never stalls
        id_nop();
        id_valid_i = 1'b1; id_memread_i = 1'b1; id_rd_i = 5'd0;
        step();
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd0;
        #1;
        check("x0_stall", {31'd0, stall_o}, 32'd0);

        // Invalid ID instruction yields a bubble
        id_nop();
        id_aluctrl_i = 4'b0111; id_rd_i = 5'd9; id_regwrite_i = 1'b1;
        step();
        check("inv_valid", {31'd0, ex_valid_o}, 32'd0);
        check("inv_alu",   {28'd0, aluctrl_o}, 32'd0);

        // Store: alusrc=1, imm=8, rs2=6 forwarded from EX/MEM
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd1; id_rs1_data_i = 32'h200;
        id_rs2_i = 5'd6; id_rs2_data_i = 32'h66; id_imm_i = 32'd8;
        id_alusrc_i = 1'b1; id_memwrite_i = 1'b1;
        step();
        id_nop();
        exmem_regwrite_i = 1'b1; exmem_rd_i = 5'd6; exmem_result_i = 32'hAB;
        #1;
        check("st_data2", data2_o, 32'd8);
        check("st_store", ex_store_data_o, 32'hAB);
        check("st_mw",    {31'd0, ex_memwrite_o}, 32'd1);
        writers_off();

        // Reset during a stall
        load_lw4();
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd4;
        #1;
        check("rs_stall_pre", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rs_valid", {31'd0, ex_valid_o}, 32'd0);
        check("rs_stall", {31'd0, stall_o}, 32'd0);

        // Back-to-back loads to x4: each consumer stalls once
        load_lw4();
        id_nop();
        id_valid_i = 1'b1; id_rs1_i = 5'd4; id_rd_i = 5'd4;
        id_memread_i = 1'b1; id_regwrite_i = 1'b1;
        #1;
        check("bb_stall1", {31'd0, stall_o}, 32'd1);
        step();
        check("bb_bub", {31'd0, stall_o}, 32'd0);
        step();
        check("bb_lw2", {31'd0, ex_memread_o}, 32'd1);
        id_nop();
        id_valid_i = 1'b1; id_rs2_i = 5'd4;
        #1;
        check("bb_stall2", {31'd0, stall_o}, 32'd1);
        step();
        check("bb_bub2", {31'd0, stall_o}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
